// File: rtl/data_path_pkg.sv
// Shared types and constants for the data_path storage front end.
package data_path_pkg;

  localparam int unsigned DATA_WIDTH    = 16;
  localparam int unsigned WORDS_PER_ROW = 3;
  localparam int unsigned CODE_WIDTH    = 12;

  typedef enum logic [1:0] {
    TARGET_WEIGHT = 2'd0,
    TARGET_INPUT  = 2'd1,
    TARGET_LABEL  = 2'd2,
    TARGET_CODE   = 2'd3
  } target_e;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StLoad  = 2'd1,
    StWrite = 2'd2,
    StDone  = 2'd3
  } state_e;

endpackage

// File: rtl/row_index_counter.sv
// Row / layer / rows-written counters for storage_loader, with per-layer wrap
// and a flag marking the final row of the load.
module row_index_counter #(
  parameter int unsigned INDEX_WIDTH = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   load_i,
  input  logic [INDEX_WIDTH-1:0] rows_per_layer_i,
  input  logic [INDEX_WIDTH-1:0] total_rows_i,
  input  logic                   advance_i,
  input  logic                   wrap_en_i,
  output logic [INDEX_WIDTH-1:0] row_o,
  output logic [INDEX_WIDTH-1:0] layer_o,
  output logic [INDEX_WIDTH-1:0] written_o,
  output logic                   last_o
);

  logic [INDEX_WIDTH-1:0] row_q, row_d;
  logic [INDEX_WIDTH-1:0] layer_q, layer_d;
  logic [INDEX_WIDTH-1:0] written_q, written_d;
  logic [INDEX_WIDTH-1:0] rpl_q, rpl_d;
  logic [INDEX_WIDTH-1:0] total_q, total_d;

  always_comb begin
    row_d     = row_q;
    layer_d   = layer_q;
    written_d = written_q;
    rpl_d     = rpl_q;
    total_d   = total_q;
    if (load_i) begin
      row_d     = '0;
      layer_d   = '0;
      written_d = '0;
      // A zero rows-per-layer would never wrap; treat it as one row per layer.
      rpl_d     = (rows_per_layer_i == '0) ? INDEX_WIDTH'(1) : rows_per_layer_i;
      total_d   = total_rows_i;
    end else if (advance_i) begin
      written_d = written_q + INDEX_WIDTH'(1);
      if (wrap_en_i) begin
        if (row_q == rpl_q - INDEX_WIDTH'(1)) begin
          row_d   = '0;
          layer_d = layer_q + INDEX_WIDTH'(1);
        end else begin
          row_d = row_q + INDEX_WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      row_q     <= '0;
      layer_q   <= '0;
      written_q <= '0;
      rpl_q     <= '0;
      total_q   <= '0;
    end else begin
      row_q     <= row_d;
      layer_q   <= layer_d;
      written_q <= written_d;
      rpl_q     <= rpl_d;
      total_q   <= total_d;
    end
  end

  assign row_o     = row_q;
  assign layer_o   = layer_q;
  assign written_o = written_q;
  assign last_o    = (written_q + INDEX_WIDTH'(1)) == total_q;

endmodule

// File: rtl/storage_loader.sv
// Packs a serial word stream into 3-word storage rows (or single code lines) and
// issues one-cycle write strobes to the selected data_path storage.
module storage_loader
  import data_path_pkg::*;
#(
  parameter int unsigned INDEX_WIDTH = 32
) (
  input  logic                                clk_clk,
  input  logic                                reset_reset_n,
  input  logic                                start,
  input  logic [1:0]                          target,
  input  logic [INDEX_WIDTH-1:0]              rows_per_layer,
  input  logic [INDEX_WIDTH-1:0]              total_rows,
  input  logic                                in_valid,
  input  logic [DATA_WIDTH-1:0]               in_data,
  output logic                                in_ready,
  output logic [DATA_WIDTH*WORDS_PER_ROW-1:0] write_data,
  output logic [INDEX_WIDTH-1:0]              write_layer_index,
  output logic [INDEX_WIDTH-1:0]              write_row_index,
  output logic                                weight_is_write,
  output logic                                input_is_write,
  output logic                                label_is_write,
  output logic                                code_is_write,
  output logic [INDEX_WIDTH-1:0]              code_write_line,
  output logic [CODE_WIDTH-1:0]               code_write_data,
  output logic                                busy,
  output logic                                done
);

  localparam int unsigned RowW = DATA_WIDTH * WORDS_PER_ROW;
  localparam int unsigned BufW = DATA_WIDTH * (WORDS_PER_ROW - 1);
  localparam int unsigned CntW = $clog2(WORDS_PER_ROW);

  state_e                 state_q;
  target_e                target_q;
  logic [CntW-1:0]        word_cnt_q;
  logic [BufW-1:0]        row_buf_q;
  logic                   in_ready_q;
  logic [RowW-1:0]        write_data_q;
  logic [INDEX_WIDTH-1:0] write_layer_q, write_row_q, code_line_q;
  logic [CODE_WIDTH-1:0]  code_data_q;
  logic                   weight_wr_q, input_wr_q, label_wr_q, code_wr_q;
  logic                   busy_q, done_q;

  logic                   cnt_load, cnt_advance, cnt_wrap_en, cnt_last;
  logic [INDEX_WIDTH-1:0] cnt_row, cnt_layer, cnt_written;
  logic                   accept;

  assign cnt_load    = (state_q == StIdle) && start;
  assign cnt_advance = (state_q == StWrite);
  assign cnt_wrap_en = (target_q != TARGET_CODE);
  assign accept      = in_valid && in_ready_q;

  row_index_counter #(
    .INDEX_WIDTH(INDEX_WIDTH)
  ) u_row_index_counter (
    .clk_i           (clk_clk),
    .rst_ni          (reset_reset_n),
    .load_i          (cnt_load),
    .rows_per_layer_i(rows_per_layer),
    .total_rows_i    (total_rows),
    .advance_i       (cnt_advance),
    .wrap_en_i       (cnt_wrap_en),
    .row_o           (cnt_row),
    .layer_o         (cnt_layer),
    .written_o       (cnt_written),
    .last_o          (cnt_last)
  );

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q       <= StIdle;
      target_q      <= TARGET_WEIGHT;
      word_cnt_q    <= '0;
      row_buf_q     <= '0;
      in_ready_q    <= 1'b0;
      write_data_q  <= '0;
      write_layer_q <= '0;
      write_row_q   <= '0;
      code_line_q   <= '0;
      code_data_q   <= '0;
      weight_wr_q   <= 1'b0;
      input_wr_q    <= 1'b0;
      label_wr_q    <= 1'b0;
      code_wr_q     <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      weight_wr_q <= 1'b0;
      input_wr_q  <= 1'b0;
      label_wr_q  <= 1'b0;
      code_wr_q   <= 1'b0;
      done_q      <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            target_q   <= target_e'(target);
            word_cnt_q <= '0;
            row_buf_q  <= '0;
            busy_q     <= 1'b1;
            if (total_rows == '0) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              state_q    <= StLoad;
              in_ready_q <= 1'b1;
            end
          end
        end
        StLoad: begin
          if (accept) begin
            if (target_q == TARGET_CODE) begin
              code_data_q <= in_data[CODE_WIDTH-1:0];
              code_line_q <= cnt_written;
              code_wr_q   <= 1'b1;
              in_ready_q  <= 1'b0;
              state_q     <= StWrite;
            end else if (word_cnt_q == CntW'(WORDS_PER_ROW - 1)) begin
              // Earlier words sit in the upper bits, so the first word lands on top.
              write_data_q  <= {row_buf_q, in_data};
              write_layer_q <= cnt_layer;
              write_row_q   <= cnt_row;
              row_buf_q     <= '0;
              word_cnt_q    <= '0;
              weight_wr_q   <= (target_q == TARGET_WEIGHT);
              input_wr_q    <= (target_q == TARGET_INPUT);
              label_wr_q    <= (target_q == TARGET_LABEL);
              in_ready_q    <= 1'b0;
              state_q       <= StWrite;
            end else begin
              row_buf_q  <= {row_buf_q[BufW-DATA_WIDTH-1:0], in_data};
              word_cnt_q <= word_cnt_q + CntW'(1);
            end
          end
        end
        StWrite: begin
          if (cnt_last) begin
            state_q <= StDone;
            done_q  <= 1'b1;
          end else begin
            state_q    <= StLoad;
            in_ready_q <= 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready          = in_ready_q;
  assign write_data        = write_data_q;
  assign write_layer_index = write_layer_q;
  assign write_row_index   = write_row_q;
  assign weight_is_write   = weight_wr_q;
  assign input_is_write    = input_wr_q;
  assign label_is_write    = label_wr_q;
  assign code_is_write     = code_wr_q;
  assign code_write_line   = code_line_q;
  assign code_write_data   = code_data_q;
  assign busy              = busy_q;
  assign done              = done_q;

endmodule

// File: tb/tb_storage_loader.sv
// Bench for storage_loader: directed literal loads plus randomized loads against
// a transaction-level model of rows, strobes, busy and done.
module tb_storage_loader;

  logic        clk_clk = 1'b0;
  logic        reset_reset_n;
  logic        start;
  logic [1:0]  target;
  logic [31:0] rows_per_layer;
  logic [31:0] total_rows;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic [47:0] write_data;
  logic [31:0] write_layer_index;
  logic [31:0] write_row_index;
  logic        weight_is_write, input_is_write, label_is_write, code_is_write;
  logic [31:0] code_write_line;
  logic [11:0] code_write_data;
  logic        busy;
  logic        done;

  storage_loader #(
    .INDEX_WIDTH(32)
  ) dut (
    .clk_clk          (clk_clk),
    .reset_reset_n    (reset_reset_n),
    .start            (start),
    .target           (target),
    .rows_per_layer   (rows_per_layer),
    .total_rows       (total_rows),
    .in_valid         (in_valid),
    .in_data          (in_data),
    .in_ready         (in_ready),
    .write_data       (write_data),
    .write_layer_index(write_layer_index),
    .write_row_index  (write_row_index),
    .weight_is_write  (weight_is_write),
    .input_is_write   (input_is_write),
    .label_is_write   (label_is_write),
    .code_is_write    (code_is_write),
    .code_write_line  (code_write_line),
    .code_write_data  (code_write_data),
    .busy             (busy),
    .done             (done)
  );

  always #5 clk_clk = ~clk_clk;

  typedef struct {
    logic [47:0] data;
    logic [31:0] layer;
    logic [31:0] row;
    logic [31:0] line;
    logic [11:0] cdata;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] words_q[$];
  int          n_compared = 0;
  int          n_mismatched = 0;

  // Model state for the current cycle (valid at each falling edge).
  bit          m_busy, m_done, m_due;
  logic [1:0]  m_tgt;
  logic [31:0] m_total, m_rows;
  int          m_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_compared++;
    if (act !== req) begin
      n_mismatched++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push_mat(input logic [47:0] d, input logic [31:0] layer, input logic [31:0] row);
    exp_t e;
    e = '{data: d, layer: layer, row: row, line: '0, cdata: '0};
    exp_q.push_back(e);
  endtask

  task automatic push_code(input logic [31:0] line, input logic [11:0] cd);
    exp_t e;
    e = '{data: '0, layer: '0, row: '0, line: line, cdata: cd};
    exp_q.push_back(e);
  endtask

  // Per-cycle comparison against the model, then advance the model one cycle.
  always @(negedge clk_clk) begin : cmp
    logic [3:0] stb;
    bit         n_busy, n_done, n_due;
    exp_t       e;
    if (!reset_reset_n) begin
      chk("reset_outputs", {in_ready, weight_is_write, input_is_write, label_is_write,
                            code_is_write, busy, done, |write_data, |write_layer_index,
                            |write_row_index, |code_write_line, |code_write_data}, '0);
      m_busy = 0; m_done = 0; m_due = 0; m_cnt = 0; m_rows = '0;
    end else begin
      stb = {code_is_write, label_is_write, input_is_write, weight_is_write};
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      chk("in_ready", in_ready, m_busy && !m_due && !m_done);
      chk("strobes", stb, m_due ? (4'b0001 << m_tgt) : 4'b0000);
      if (m_due) begin
        if (exp_q.size() == 0) begin
          chk("exp_available", 0, 1);
        end else begin
          e = exp_q.pop_front();
          if (m_tgt == 2'd3) begin
            chk("code_line", code_write_line, e.line);
            chk("code_data", code_write_data, e.cdata);
          end else begin
            chk("write_data", write_data, e.data);
            chk("layer_index", write_layer_index, e.layer);
            chk("row_index", write_row_index, e.row);
          end
        end
      end
      n_busy = m_busy; n_done = 0; n_due = 0;
      if (m_done) n_busy = 0;
      if (m_due) begin
        m_rows++;
        if (m_rows == m_total) n_done = 1;
      end
      if (m_busy && !m_due && !m_done && in_valid) begin
        m_cnt++;
        if (m_cnt == ((m_tgt == 2'd3) ? 1 : 3)) begin
          n_due = 1;
          m_cnt = 0;
        end
      end
      if (!m_busy && start) begin
        n_busy  = 1;
        m_tgt   = target;
        m_total = total_rows;
        m_rows  = '0;
        m_cnt   = 0;
        if (total_rows == '0) n_done = 1;
      end
      m_busy = n_busy; m_done = n_done; m_due = n_due;
    end
  end

  // Called just after a rising edge; leaves the bench one cycle later at edge+1.
  task automatic start_load(input logic [1:0] t, input logic [31:0] rpl, input logic [31:0] tot);
    start = 1'b1; target = t; rows_per_layer = rpl; total_rows = tot;
    @(posedge clk_clk); #1;
    start = 1'b0; target = 2'($urandom); rows_per_layer = $urandom; total_rows = $urandom;
  endtask

  task automatic feed(input int stall_pct, input logic [7:0] pat, input int pat_len,
                      input int inj_at, input logic [1:0] inj_tgt);
    int idx = 0;
    int it = 0;
    bit acc;
    while (idx < words_q.size() && it < 2000) begin
      if (it < pat_len) in_valid = pat[it[2:0]];
      else              in_valid = ($urandom_range(99) >= stall_pct);
      in_data = in_valid ? words_q[idx] : 16'($urandom);
      if (it == inj_at) begin
        start = 1'b1; target = inj_tgt; total_rows = 32'd0;
      end
      @(negedge clk_clk);
      acc = in_valid && in_ready;
      @(posedge clk_clk); #1;
      start = 1'b0;
      if (acc) idx++;
      it++;
    end
    in_valid = 1'b0;
    in_data  = '0;
    if (idx < words_q.size()) chk("feed_timeout", 64'(idx), 64'(words_q.size()));
  endtask

  task automatic wait_done();
    bit seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk_clk);
      if (done) seen = 1;
    end
    chk("done_seen", seen, 1);
    @(posedge clk_clk); #1;
  endtask

  initial begin
    logic [1:0]  t;
    logic [31:0] rpl, tot, eff;
    logic [15:0] w0, w1, w2;
    reset_reset_n = 1'b0; start = 1'b0; target = '0; rows_per_layer = '0; total_rows = '0;
    in_valid = 1'b0; in_data = '0;
    repeat (3) @(posedge clk_clk);
    #1 reset_reset_n = 1'b1;
    @(posedge clk_clk); #1;

    // Weight load, rows_per_layer 2, three rows.
    words_q.delete();
    for (int i = 1; i <= 9; i++) words_q.push_back(16'(i));
    push_mat(48'h000100020003, 32'd0, 32'd0);
    push_mat(48'h000400050006, 32'd0, 32'd1);
    push_mat(48'h000700080009, 32'd1, 32'd0);
    start_load(2'd0, 32'd2, 32'd3);
    feed(0, 8'h00, 0, -1, 2'd0);
    wait_done();

    // Code load, upper bits dropped.
    words_q = '{16'hF123, 16'h0ABC, 16'h0001, 16'h0FFF};
    push_code(32'd0, 12'h123);
    push_code(32'd1, 12'hABC);
    push_code(32'd2, 12'h001);
    push_code(32'd3, 12'hFFF);
    start_load(2'd3, 32'd0, 32'd4);
    feed(0, 8'h00, 0, -1, 2'd0);
    wait_done();

    // Label load with valid pattern 1-0-0-1-1.
    words_q = '{16'hAAAA, 16'hBBBB, 16'hCCCC};
    push_mat(48'hAAAABBBBCCCC, 32'd0, 32'd0);
    start_load(2'd2, 32'd5, 32'd1);
    feed(0, 8'b0001_1001, 5, -1, 2'd0);
    wait_done();

    // Zero-row input load: done and busy for exactly one cycle.
    start_load(2'd1, 32'd1, 32'd0);
    chk("zero_done", done, 1);
    chk("zero_busy", busy, 1);
    @(posedge clk_clk); #1;
    chk("zero_done_fall", done, 0);
    chk("zero_busy_fall", busy, 0);
    chk("zero_no_strobe", {weight_is_write, input_is_write, label_is_write, code_is_write}, 0);

    // Start during load with another target is ignored.
    words_q.delete();
    for (int i = 16; i < 22; i++) words_q.push_back(16'(i));
    push_mat(48'h001000110012, 32'd0, 32'd0);
    push_mat(48'h001300140015, 32'd1, 32'd0);
    start_load(2'd0, 32'd1, 32'd2);
    feed(0, 8'h00, 0, 1, 2'd3);
    wait_done();

    // Reset after the second word of a row, then a clean load.
    words_q = '{16'h1111, 16'h2222};
    start_load(2'd0, 32'd2, 32'd3);
    feed(0, 8'h00, 0, -1, 2'd0);
    reset_reset_n = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_write_data", write_data, 0);
    exp_q.delete();
    @(posedge clk_clk); #1;
    reset_reset_n = 1'b1;
    @(posedge clk_clk); #1;
    words_q = '{16'h000A, 16'h000B, 16'h000C};
    push_mat(48'h000A000B000C, 32'd0, 32'd0);
    start_load(2'd0, 32'd3, 32'd1);
    feed(0, 8'h00, 0, -1, 2'd0);
    wait_done();

    // Randomized loads.
    for (int n = 0; n < 30; n++) begin
      t   = 2'($urandom_range(3));
      rpl = 32'($urandom_range(3));
      tot = 32'($urandom_range(5));
      eff = (rpl == 0) ? 32'd1 : rpl;
      words_q.delete();
      for (int k = 0; k < int'(tot); k++) begin
        if (t == 2'd3) begin
          w0 = 16'($urandom);
          words_q.push_back(w0);
          push_code(32'(k), w0[11:0]);
        end else begin
          w0 = 16'($urandom); w1 = 16'($urandom); w2 = 16'($urandom);
          words_q.push_back(w0); words_q.push_back(w1); words_q.push_back(w2);
          push_mat({w0, w1, w2}, 32'(k) / eff, 32'(k) % eff);
        end
      end
      start_load(t, rpl, tot);
      if (tot != 0) feed($urandom_range(60), 8'h00, 0,
                         ($urandom_range(1) == 1) ? $urandom_range(4) : -1, 2'($urandom));
      wait_done();
      repeat ($urandom_range(3)) @(posedge clk_clk);
      #1;
    end

    chk("exp_drained", 64'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/storage_loader.md
# storage_loader

Front-end loader for `data_path`. It accepts a serial stream of 16-bit fixed-point words (or 12-bit instruction words) and packs them into storage rows, three words per 48-bit row. It generates `write_data`, `write_layer_index` and `write_row_index`, plus a one-cycle `is_write` strobe, for the weight, input, label or code storage. It replaces hand-driven row writes when initialising `data_path` before `controller_enable` is raised.

## Interface
- `DATA_WIDTH`, 16: element width.
- `WORDS_PER_ROW`, 3: elements per matrix-storage row.
- `INDEX_WIDTH`, 32: width of layer, row and line indices.
- `CODE_WIDTH`, 12: instruction width.
- `clk_clk` in 1: single clock, rising edge.
- `reset_reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse that begins a load; sampled only in IDLE.
- `target` in 2: storage select, captured at `start`. 0 = weight, 1 = input, 2 = label, 3 = code.
- `rows_per_layer` in INDEX_WIDTH: rows before the layer index advances; captured at `start`; 0 is treated as 1.
- `total_rows` in INDEX_WIDTH: rows (or code lines) to write; captured at `start`.
- `in_valid` in 1, `in_data` in DATA_WIDTH, `in_ready` out 1: word stream with valid/ready handshake.
- `write_data` out DATA_WIDTH*WORDS_PER_ROW: packed row.
- `write_layer_index` out INDEX_WIDTH, `write_row_index` out INDEX_WIDTH.
- `weight_is_write`, `input_is_write`, `label_is_write`, `code_is_write` out 1: one-cycle write strobes.
- `code_write_line` out INDEX_WIDTH, `code_write_data` out CODE_WIDTH.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle completion pulse.

## Operation
- Reset value of every output is 0. The FSM returns to IDLE and all counters and the row buffer clear. Reset mid-load abandons the load with no further strobes.
- FSM states: IDLE, LOAD, WRITE, DONE.
- IDLE + `start`:
  - capture `target`, `rows_per_layer`, `total_rows`;
  - clear word count, row index, layer index and rows written;
  - go to LOAD, or go directly to DONE if `total_rows` == 0.
- LOAD:
  - `in_ready` = 1; a word is accepted when `in_valid && in_ready`.
  - Matrix targets: the first accepted word lands in bits [47:32], the second in [31:16], the third in [15:0]. After the third word, go to WRITE.
  - Code target: the first accepted word is taken as `in_data[CODE_WIDTH-1:0]` (upper bits ignored); go to WRITE.
- WRITE (one cycle):
  - `in_ready` = 0.
  - Exactly one strobe selected by `target` is high.
  - Matrix targets: `write_data`, `write_layer_index` and `write_row_index` are valid.
  - Code target: `code_write_line` = rows written and `code_write_data` are valid. Layer and row indices are not used.
  - On exit, increment rows written. Row index wraps to 0 after `rows_per_layer`-1 and the layer index increments at the wrap; the wrap applies to matrix targets only.
  - If rows written equals `total_rows`, go to DONE; otherwise go to LOAD.
- DONE (one cycle): `done` = 1, then go to IDLE.
- `start` outside IDLE is ignored.
- `write_data` and the index outputs hold their last values between strobes. Downstream must qualify them only by the strobes.
- `in_valid` gaps stall LOAD indefinitely and have no timeout.

## Timing
- Word acceptance occurs on the clock edge where `in_valid && in_ready`.
- Strobe latency: the last word of a row is accepted at edge N; the strobe is high for the cycle following edge N; `in_ready` is low in that same cycle.
- Throughput: a matrix row takes 3 accept cycles + 1 write cycle; a code line takes 1 + 1.
- `done` is high in the cycle after the final strobe. `busy` falls in the same edge that `done` falls.
- `start` to first `in_ready`: `in_ready` is high in the cycle after the `start` edge.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package `data_path_pkg` holds:
  - the target encoding enum (TARGET_WEIGHT=0, TARGET_INPUT=1, TARGET_LABEL=2, TARGET_CODE=3);
  - DATA_WIDTH, WORDS_PER_ROW, CODE_WIDTH constants;
  - the FSM state enum.
- One natural sub-module is `row_index_counter`. It owns row, layer and rows-written counters with the `rows_per_layer` wrap and the `total_rows` terminal flag. The FSM and packing stay in the top level.

## Test plan
- Weight load, `rows_per_layer`=2, `total_rows`=3, words 0x0001..0x0009 → three `weight_is_write` strobes:
  - 0x000100020003 at layer 0 row 0;
  - 0x000400050006 at layer 0 row 1;
  - 0x000700080009 at layer 1 row 0;
  - then `done` the cycle after the last strobe.
- Code load, `total_rows`=4, words 0xF123, 0x0ABC, 0x0001, 0x0FFF → `code_is_write` ×4 with lines 0–3 and data 0x123, 0xABC, 0x001, 0xFFF; no matrix strobes.
- `in_valid` toggled 1-0-0-1-1 with label target → only accepted words are packed; one `label_is_write` with the correct row; `in_ready` low during the strobe cycle.
- `total_rows`=0, input target → no strobes; `done` one cycle after `start`; `busy` high for that one cycle.
- `start` asserted during LOAD with a different target → ignored; the original target strobe is unchanged.
- `reset_reset_n` low after the 2nd word of a row → all outputs 0 immediately. A new load after release starts at row 0 and layer 0 with an empty buffer.
